wb_cpu_master: RTL and testbench

Wishbone initiator that turns single CPU bus requests (6502-style address/data/read-write) into Wishbone transactions toward the console peripherals (TIA, RIOT, cartridge ROM).
- Strobes each transaction for exactly one cycle, waits for a registered ack and returns read data to the CPU with a one-cycle completion pulse.
- Blocks new requests while the peripheral stall line (WSYNC) is high.
- Recovers from a missing ack by timing out.

---
 rtl/wb_cpu_master.sv | 79 +++++++
 tb/tb_wb_cpu_master.sv | 117 +++++++++++
 2 files changed

// File: rtl/wb_cpu_master.sv
// wb_cpu_master: turns single 6502-style CPU requests into one-strobe Wishbone transfers,
// holding off while stall_i is high and completing with TIMEOUT_DATA/cpu_err if no ack arrives.
module wb_cpu_master #(
   parameter int WB_DATA_WIDTH = 8,
   parameter int WB_ADDR_WIDTH = 7,
   parameter int CPU_ADDR_WIDTH = 13,
   parameter int TIMEOUT = 15,
   parameter logic [WB_DATA_WIDTH-1:0] TIMEOUT_DATA = 8'hFF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
   input  logic [WB_DATA_WIDTH-1:0]  cpu_dout,
   output logic [WB_DATA_WIDTH-1:0]  cpu_din,
   output logic                      cpu_ack,
   output logic                      cpu_err,
   output logic                      stb_o,
   output logic                      we_o,
   output logic [WB_ADDR_WIDTH-1:0]  adr_o,
   output logic [WB_DATA_WIDTH-1:0]  dat_o,
   input  logic                      ack_i,
   input  logic [WB_DATA_WIDTH-1:0]  dat_i,
   input  logic                      stall_i,
   output logic                      busy
);
   typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   state_t state;
   logic [7:0] cnt;
   assign busy = state != IDLE;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         stb_o   <= 1'b0;
         we_o    <= 1'b0;
         adr_o   <= '0;
         dat_o   <= '0;
         cpu_din <= '0;
         cpu_ack <= 1'b0;
         cpu_err <= 1'b0;
      end else
         case (state)
            IDLE:
               if (cpu_req && !stall_i) begin
                  adr_o <= cpu_addr[WB_ADDR_WIDTH-1:0];
                  dat_o <= cpu_dout;
                  we_o  <= cpu_we;
                  stb_o <= 1'b1;
                  cnt   <= '0;
                  state <= STROBE;
               end
            STROBE: begin
               stb_o <= 1'b0;
               state <= WAIT;
            end
            // ack wins over timeout when both land in the same cycle
            WAIT: begin
               cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
               if (ack_i) begin
                  if (!we_o) cpu_din <= dat_i;
                  cpu_ack <= 1'b1;
                  state   <= DONE;
               end else if (cnt == LAST) begin
                  if (!we_o) cpu_din <= TIMEOUT_DATA;
                  cpu_ack <= 1'b1;
                  cpu_err <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               cpu_ack <= 1'b0;
               cpu_err <= 1'b0;
               state   <= IDLE;
            end
         endcase
endmodule

// File: tb/tb_wb_cpu_master.sv
// tb_wb_cpu_master: directed and random transfers against a transaction-level model of
// latency, timeout, read-data hold and strobe count.
module tb_wb_cpu_master;
   localparam int T = 15;
   logic clk_i = 1'b0, rst_i = 1'b1;
   logic cpu_req = 1'b0, cpu_we = 1'b0;
   logic [12:0] cpu_addr = '0;
   logic [7:0] cpu_dout = '0, cpu_din, dat_o, dat_i = '0;
   logic cpu_ack, cpu_err, stb_o, we_o, busy;
   logic [6:0] adr_o;
   logic ack_i = 1'b0, stall_i = 1'b0;
   int n_cmp = 0, n_bad = 0, n_stb = 0, n_wr = 0;
   logic [7:0] din_m = '0;

   wb_cpu_master dut (
      .clk_i(clk_i), .rst_i(rst_i), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
      .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i),
      .dat_i(dat_i), .stall_i(stall_i), .busy(busy)
   );

   always #5 clk_i = ~clk_i;

   // slave view: every strobed cycle is one access
   always @(posedge clk_i)
      if (!rst_i && stb_o) begin
         n_stb++;
         if (we_o) n_wr++;
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // j: WAIT cycle (0 = first) in which the slave acks; j >= T means never
   task automatic xfer(input logic we, input logic [12:0] a, input logic [7:0] d, input logic [7:0] rd,
                       input int j, input int stall, input int rst_at, input logic stray_i, input logic stray_s);
      int s0 = n_stb;
      int w0 = n_wr;
      int done_w = -1;
      int exp_w;
      if (stray_i) begin
         ack_i = 1'b1;
         @(negedge clk_i);
         ack_i = 1'b0;
         check("stray_idle", 32'({busy, cpu_ack}), 32'd0);
      end
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_dout = d; stall_i = stall > 0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk_i);
         check("stall_stb", 32'(stb_o), 32'd0);
      end
      stall_i = 1'b0;
      @(negedge clk_i);
      check("stb", 32'({stb_o, we_o, adr_o, dat_o}), 32'({1'b1, we, a[6:0], d}));
      cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 13'($urandom); cpu_dout = 8'($urandom);
      ack_i = stray_s;
      for (int w = 0; w < 40; w++) begin
         @(negedge clk_i);
         if (w == rst_at) begin
            #2 rst_i = 1'b1;
            #1 check("rst_async", 32'({stb_o, busy, cpu_ack, cpu_din}), 32'd0);
            @(negedge clk_i);
            rst_i = 1'b0; ack_i = 1'b0; stall_i = 1'b0; din_m = '0;
            check("rst_no_ack", 32'({busy, cpu_ack}), 32'd0);
            return;
         end
         if (cpu_ack) begin
            done_w = w;
            break;
         end
         ack_i = (w == j);
         dat_i = (w == j) ? rd : 8'($urandom);
         stall_i = 1'($urandom);
      end
      ack_i = 1'b0; stall_i = 1'b0;
      exp_w = (j < T) ? j + 1 : T;
      if (!we) din_m = (j < T) ? rd : 8'hFF;
      check("ack_latency", done_w, exp_w);
      check("done", 32'({cpu_err, busy, cpu_din}), 32'({(j >= T), 1'b1, din_m}));
      check("one_stb", n_stb - s0, 1);
      check("writes", n_wr - w0, 32'(we));
      @(negedge clk_i);
      check("idle", 32'({busy, cpu_ack, cpu_err, stb_o, cpu_din}), 32'({4'b0, din_m}));
   endtask

   initial begin
      @(negedge clk_i);
      @(negedge clk_i);
      check("reset", 32'({stb_o, we_o, cpu_ack, cpu_err, busy, adr_o, dat_o, cpu_din}), 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      xfer(1'b1, 13'h0009, 8'h1E, 8'h00, 0, 0, -1, 1'b0, 1'b0);
      xfer(1'b0, 13'h000C, 8'h00, 8'h80, 0, 0, -1, 1'b0, 1'b0);
      xfer(1'b1, 13'h0005, 8'h33, 8'h55, 0, 0, -1, 1'b0, 1'b0);
      check("din_held", 32'(cpu_din), 32'h80);
      xfer(1'b0, 13'h0001, 8'h00, 8'h42, 2, 10, -1, 1'b0, 1'b0);
      xfer(1'b0, 13'h0002, 8'h00, 8'h99, 999, 0, -1, 1'b0, 1'b0);
      xfer(1'b0, 13'h1F7A, 8'h00, 8'h77, 3, 0, -1, 1'b0, 1'b0);
      xfer(1'b0, 13'h0003, 8'h00, 8'h11, 999, 0, 5, 1'b0, 1'b0);
      xfer(1'b1, 13'h0044, 8'hC3, 8'h00, 0, 0, -1, 1'b0, 1'b0);
      xfer(1'b0, 13'h0004, 8'h00, 8'hA5, 4, 0, -1, 1'b1, 1'b1);
      xfer(1'b0, 13'h0006, 8'h00, 8'h3C, T - 1, 0, -1, 1'b0, 1'b0);
      for (int n = 0; n < 300; n++)
         xfer(1'($urandom), 13'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(0, 5),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
              ($urandom_range(0, 30) == 0) ? $urandom_range(0, 3) : -1,
              1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
